// File: rtl/noise_channel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : noise_channel_ctrl
//  Description : Noise-channel control stage. Runs the length counter, the
//                volume envelope and the channel enable, and presents the
//                registered volume / waveform-enable / LFSR-width controls
//                consumed by the noise waveform generator.
//                Optional build macro: NOISE_LEN_EXTRA_CLK_EN enables the
//                extra length clock on a 0->1 edge of I_LEN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module noise_channel_ctrl #(
   parameter int LEN_BITS     = 6,
   parameter int ENV_PER_BITS = 3
) (
   input  logic                    I_SHIFT_CLOCK,
   input  logic                    I_RESET,
   input  logic                    I_TRIGGER,
   input  logic                    I_LEN_WRITE,
   input  logic [LEN_BITS-1:0]     I_LEN_LOAD,
   input  logic                    I_LEN_EN,
   input  logic                    I_TICK_LEN,
   input  logic                    I_TICK_ENV,
   input  logic [3:0]              I_INIT_VOL,
   input  logic                    I_ENV_DIR,
   input  logic [ENV_PER_BITS-1:0] I_ENV_PERIOD,
   input  logic                    I_WIDTH_MODE,
   input  logic                    I_LEN_NEXT_SKIP,
   output logic [3:0]              O_VOLUME,
   output logic                    O_WAVEFORM_EN,
   output logic                    O_BIT_WIDTH,
   output logic                    O_ACTIVE
);

   typedef enum logic [0:0] {
      ST_OFF = 1'b0,
      ST_RUN = 1'b1
   } state_t;

   localparam logic [LEN_BITS:0]     C_LEN_MAX = (LEN_BITS+1)'(1) << LEN_BITS;
   localparam logic [LEN_BITS:0]     C_LEN_ONE = (LEN_BITS+1)'(1);
   localparam logic [ENV_PER_BITS-1:0] C_ENV_ONE = ENV_PER_BITS'(1);

   state_t                  state_q,     state_d;
   logic [LEN_BITS:0]       remaining_q, remaining_d;
   logic [ENV_PER_BITS-1:0] env_timer_q, env_timer_d;
   logic [3:0]              volume_q,    volume_d;
   logic [3:0]              vol_out_q,   vol_out_d;
   logic                    active_q,    active_d;
   logic                    width_q;

   logic                    w_dac_on;
   logic                    w_len_expire;
   logic                    w_extra_clk;

`ifdef NOISE_LEN_EXTRA_CLK_EN
   logic                    len_en_q;

   // Registered copy of the length enable for rising-edge detection
   always_ff @(posedge I_SHIFT_CLOCK) begin
      if (I_RESET) len_en_q <= 1'b0;
      else         len_en_q <= I_LEN_EN;
   end

   assign w_extra_clk = I_LEN_EN & ~len_en_q & I_LEN_NEXT_SKIP;
`else
   logic                    unused_len_skip;
   assign unused_len_skip = I_LEN_NEXT_SKIP;
   assign w_extra_clk     = 1'b0;
`endif

   // The DAC is powered whenever the envelope could produce non-zero output
   assign w_dac_on = (I_INIT_VOL != 4'd0) | I_ENV_DIR;

   // State register and all datapath/output registers
   always_ff @(posedge I_SHIFT_CLOCK) begin
      if (I_RESET) begin
         state_q     <= ST_OFF;
         remaining_q <= '0;
         env_timer_q <= '0;
         volume_q    <= 4'd0;
         vol_out_q   <= 4'd0;
         active_q    <= 1'b0;
         width_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         env_timer_q <= env_timer_d;
         volume_q    <= volume_d;
         vol_out_q   <= vol_out_d;
         active_q    <= active_d;
         width_q     <= I_WIDTH_MODE;
      end
   end

   // Next-state: length counter, envelope, trigger and channel enable
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      env_timer_d  = env_timer_q;
      volume_d     = volume_q;
      w_len_expire = 1'b0;

      // Length counter: a write beats a tick; a trigger drops the tick
      if (I_LEN_WRITE) begin
         remaining_d = C_LEN_MAX - {1'b0, I_LEN_LOAD};
      end else if (I_TICK_LEN && !I_TRIGGER && I_LEN_EN && (remaining_q != '0)) begin
         remaining_d = remaining_q - C_LEN_ONE;
         if (remaining_d == '0) w_len_expire = 1'b1;
      end

      // Extra length clock lands before the trigger's zero-check
      if (w_extra_clk && (remaining_d != '0)) begin
         remaining_d = remaining_d - C_LEN_ONE;
         if (remaining_d == '0) w_len_expire = 1'b1;
      end

      if (I_TRIGGER) begin
         volume_d    = I_INIT_VOL;
         env_timer_d = I_ENV_PERIOD;
         if (remaining_d == '0) remaining_d = C_LEN_MAX;
         state_d     = w_dac_on ? ST_RUN : ST_OFF;
      end else begin
         // Envelope only advances while running with a non-zero period
         if (I_TICK_ENV && (state_q == ST_RUN) && (I_ENV_PERIOD != '0)) begin
            if (env_timer_q <= C_ENV_ONE) begin
               env_timer_d = I_ENV_PERIOD;
               if (I_ENV_DIR && (volume_q != 4'd15))
                  volume_d = volume_q + 4'd1;
               else if (!I_ENV_DIR && (volume_q != 4'd0))
                  volume_d = volume_q - 4'd1;
            end else begin
               env_timer_d = env_timer_q - C_ENV_ONE;
            end
         end
         if (!w_dac_on || w_len_expire) state_d = ST_OFF;
      end

      active_d  = (state_d == ST_RUN);
      vol_out_d = active_d ? volume_d : 4'd0;
   end

   assign O_VOLUME      = vol_out_q;
   assign O_WAVEFORM_EN = active_q;
   assign O_ACTIVE      = active_q;
   assign O_BIT_WIDTH   = width_q;

endmodule
`default_nettype wire

// File: tb/tb_noise_channel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noise_channel_ctrl
//  Description : Directed self-checking bench for noise_channel_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_noise_channel_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig, len_wr, len_en, tick_len, tick_env, env_dir, width_mode, skip;
   logic [5:0] len_load;
   logic [3:0] init_vol;
   logic [2:0] env_per;
   logic [3:0] vol;
   logic       wf_en, bit_w, active;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   noise_channel_ctrl #(.LEN_BITS(6), .ENV_PER_BITS(3)) dut (
      .I_SHIFT_CLOCK   (clk),
      .I_RESET         (rst),
      .I_TRIGGER       (trig),
      .I_LEN_WRITE     (len_wr),
      .I_LEN_LOAD      (len_load),
      .I_LEN_EN        (len_en),
      .I_TICK_LEN      (tick_len),
      .I_TICK_ENV      (tick_env),
      .I_INIT_VOL      (init_vol),
      .I_ENV_DIR       (env_dir),
      .I_ENV_PERIOD    (env_per),
      .I_WIDTH_MODE    (width_mode),
      .I_LEN_NEXT_SKIP (skip),
      .O_VOLUME        (vol),
      .O_WAVEFORM_EN   (wf_en),
      .O_BIT_WIDTH     (bit_w),
      .O_ACTIVE        (active)
   );

   // one clock edge, then settle; strobes are cleared afterwards
   task automatic step();
      @(posedge clk);
      #1;
      trig = 0; len_wr = 0; tick_len = 0; tick_env = 0; rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; trig = 1; len_wr = 1; tick_len = 1; tick_env = 1;
      init_vol = 4'd7; width_mode = 1;
      step();
      checks++; if (vol !== 4'd0)    begin errors++; $display("FAIL reset_vol got=%0d exp=0", vol); end
      checks++; if (wf_en !== 1'b0)  begin errors++; $display("FAIL reset_wf got=%b exp=0", wf_en); end
      checks++; if (bit_w !== 1'b0)  begin errors++; $display("FAIL reset_width got=%b exp=0", bit_w); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
      width_mode = 0;
   endtask

   task automatic test_trigger_frozen_env();
      init_vol = 4'd9; env_dir = 0; env_per = 3'd0; len_en = 0;
      trig = 1; step();
      checks++; if (vol !== 4'd9)    begin errors++; $display("FAIL trig_vol got=%0d exp=9", vol); end
      checks++; if (wf_en !== 1'b1)  begin errors++; $display("FAIL trig_wf got=%b exp=1", wf_en); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL trig_active got=%b exp=1", active); end
      for (int i = 0; i < 100; i++) begin tick_env = 1; step(); end
      checks++; if (vol !== 4'd9)    begin errors++; $display("FAIL frozen_env_vol got=%0d exp=9", vol); end
   endtask

   task automatic test_length();
      len_load = 6'd60; len_wr = 1; len_en = 1; trig = 1; step();   // remaining 4
      for (int i = 1; i <= 3; i++) begin
         tick_len = 1; step();
         checks++; if (active !== 1'b1) begin errors++; $display("FAIL len_tick%0d_active got=%b exp=1", i, active); end
      end
      tick_len = 1; step();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL len_expire_active got=%b exp=0", active); end
      step();
      checks++; if (vol !== 4'd0)    begin errors++; $display("FAIL len_expire_vol got=%0d exp=0", vol); end
      // further ticks at zero must not wrap; a trigger then reloads a full 64
      for (int i = 0; i < 3; i++) begin tick_len = 1; step(); end
      trig = 1; step();
      for (int i = 0; i < 63; i++) begin tick_len = 1; step(); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL len64_tick63_active got=%b exp=1", active); end
      tick_len = 1; step();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL len64_tick64_active got=%b exp=0", active); end
      len_en = 0;
   endtask

   task automatic test_envelope();
      logic [3:0] exp_dec [4];
      logic [3:0] exp_inc [4];
      exp_dec[0] = 4'd2; exp_dec[1] = 4'd1; exp_dec[2] = 4'd1; exp_dec[3] = 4'd0;
      exp_inc[0] = 4'd14; exp_inc[1] = 4'd15; exp_inc[2] = 4'd15; exp_inc[3] = 4'd15;
      init_vol = 4'd2; env_dir = 0; env_per = 3'd2; trig = 1; step();
      checks++; if (vol !== 4'd2) begin errors++; $display("FAIL env_dec_start got=%0d exp=2", vol); end
      for (int i = 0; i < 4; i++) begin
         tick_env = 1; step();
         checks++; if (vol !== exp_dec[i]) begin errors++; $display("FAIL env_dec_tick%0d got=%0d exp=%0d", i+1, vol, exp_dec[i]); end
      end
      for (int i = 0; i < 6; i++) begin tick_env = 1; step(); end
      checks++; if (vol !== 4'd0)    begin errors++; $display("FAIL env_dec_floor got=%0d exp=0", vol); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL env_dec_floor_active got=%b exp=1", active); end
      init_vol = 4'd14; env_dir = 1; trig = 1; step();
      for (int i = 0; i < 4; i++) begin
         tick_env = 1; step();
         checks++; if (vol !== exp_inc[i]) begin errors++; $display("FAIL env_inc_tick%0d got=%0d exp=%0d", i+1, vol, exp_inc[i]); end
      end
   endtask

   task automatic test_dac();
      rst = 1; step();
      init_vol = 4'd0; env_dir = 0; env_per = 3'd0; trig = 1; step();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL dac_off_trig_active got=%b exp=0", active); end
      checks++; if (wf_en !== 1'b0)  begin errors++; $display("FAIL dac_off_trig_wf got=%b exp=0", wf_en); end
      env_dir = 1; trig = 1; step();
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL dac_dir_trig_active got=%b exp=1", active); end
      checks++; if (vol !== 4'd0)    begin errors++; $display("FAIL dac_dir_trig_vol got=%0d exp=0", vol); end
      init_vol = 4'd5; trig = 1; step();
      checks++; if (vol !== 4'd5)    begin errors++; $display("FAIL dac_run_vol got=%0d exp=5", vol); end
      init_vol = 4'd0; env_dir = 0; step();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL dac_drop_active got=%b exp=0", active); end
      checks++; if (vol !== 4'd0)    begin errors++; $display("FAIL dac_drop_vol got=%0d exp=0", vol); end
   endtask

   task automatic test_simultaneous();
      init_vol = 4'd2; env_dir = 0; env_per = 3'd1; len_en = 1;
      // trigger + length tick at remaining 1: tick dropped
      len_load = 6'd63; len_wr = 1; step();
      trig = 1; tick_len = 1; step();
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL trig_tick_active got=%b exp=1", active); end
      tick_len = 1; step();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL trig_tick_rem1 got=%b exp=0", active); end
      // trigger + envelope tick: tick dropped
      trig = 1; tick_env = 1; step();
      checks++; if (vol !== 4'd2) begin errors++; $display("FAIL trig_env_vol got=%0d exp=2", vol); end
      tick_env = 1; step();
      checks++; if (vol !== 4'd1) begin errors++; $display("FAIL env_after_trig_vol got=%0d exp=1", vol); end
      // write + length tick: write wins (remaining 2)
      len_load = 6'd62; len_wr = 1; tick_len = 1; step();
      tick_len = 1; step();
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL write_tick_active got=%b exp=1", active); end
      tick_len = 1; step();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL write_tick_expire got=%b exp=0", active); end
      len_en = 0;
   endtask

   task automatic test_reset_mid();
      init_vol = 4'd11; width_mode = 1; trig = 1; step();
      checks++; if (bit_w !== 1'b1) begin errors++; $display("FAIL width_pass got=%b exp=1", bit_w); end
      rst = 1; trig = 1; len_wr = 1; step();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_reset_active got=%b exp=0", active); end
      checks++; if (vol !== 4'd0)    begin errors++; $display("FAIL mid_reset_vol got=%0d exp=0", vol); end
      checks++; if (bit_w !== 1'b0)  begin errors++; $display("FAIL mid_reset_width got=%b exp=0", bit_w); end
      width_mode = 0;
   endtask

   task automatic test_extra_clk();
      logic exp_active;
`ifdef NOISE_LEN_EXTRA_CLK_EN
      exp_active = 1'b0;
`else
      exp_active = 1'b1;
`endif
      rst = 1; step();
      len_en = 0; skip = 0; init_vol = 4'd6; env_dir = 0; env_per = 3'd0;
      len_load = 6'd63; len_wr = 1; trig = 1; step();
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL extra_setup_active got=%b exp=1", active); end
      len_en = 1; skip = 1; step();
      checks++; if (active !== exp_active) begin errors++; $display("FAIL extra_clk_active got=%b exp=%b", active, exp_active); end
      len_en = 0; skip = 0;
   endtask

   initial begin
      rst = 0; trig = 0; len_wr = 0; len_en = 0; tick_len = 0; tick_env = 0;
      env_dir = 0; width_mode = 0; skip = 0; len_load = '0; init_vol = '0; env_per = '0;
      test_reset();
      test_trigger_frozen_env();
      test_length();
      test_envelope();
      test_dac();
      test_simultaneous();
      test_reset_mid();
      test_extra_clk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
